// File: rtl/macguffin_pipe.sv
// MacGuffin block-cipher pipeline: ROUNDS unrolled Feistel rounds folded RPS per stage,
// per-beat encrypt/decrypt, bubble-collapsing AXI4-Stream flow control.
module macguffin_pipe #(
  parameter int ROUNDS = 32,
  parameter int RPS    = 1,
  parameter int USER_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROUNDS*48-1:0] round_keys,
  input  logic [63:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [USER_W-1:0]    s_axis_tuser,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tdest,
  output logic [63:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [USER_W-1:0]    m_axis_tuser,
  output logic                 m_axis_tlast
);

  localparam int RPS_SAFE = (RPS < 1) ? 1 : RPS;
  localparam int STAGES   = ROUNDS / RPS_SAFE;

  if (RPS < 1 || (ROUNDS % RPS_SAFE) != 0) begin : g_bad_cfg
    $error("macguffin_pipe: ROUNDS must be a positive multiple of RPS");
  end

  // S-box input bit positions, nibble (i*6+p) = position p of box i; p0,p1 from the
  // first control word, p2,p3 from the second, p4,p5 from the third (p0 is the MSB).
  localparam logic [191:0] SEL  = 192'h9340db_72b5f9_51fc87_c6e3a0_a421ec_f0d863_e8a741_db9652;
  localparam logic [31:0]  OPOS = 32'heac86420;
  // 64 two-bit entries per box, entry n at bits [2n+1:2n].
  localparam logic [127:0] SBOX [8] = '{
    128'hb4e1d82c7a935f06c6a93e510fb2748d,
    128'h2d7c94e3b10f68a55a3ec7d10964fb82,
    128'h93c60fa8e45b217dd87e6b21c5309af4,
    128'h6a1fc3b85d94e02727b48e6df1903ac5,
    128'hc8e31b76a24df9059f506cd23a8be417,
    128'h5f28e6b10c9d734aa6d319c4f25e8b70,
    128'h1e9b4c70d3a6852ff241b78e6c0d395a,
    128'he7523d09b8cf146a49acd2760e3bf518
  };

  function automatic logic [15:0] mg_f(input logic [47:0] t);
    logic [15:0]  x, y, z, f;
    logic [5:0]   idx;
    logic [127:0] row;
    x = t[47:32];
    y = t[31:16];
    z = t[15:0];
    f = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = {x[SEL[i*24 +: 4]],      x[SEL[i*24 + 4 +: 4]],
             y[SEL[i*24 + 8 +: 4]],  y[SEL[i*24 + 12 +: 4]],
             z[SEL[i*24 + 16 +: 4]], z[SEL[i*24 + 20 +: 4]]};
      row = SBOX[i];
      f[OPOS[i*4 +: 4] +: 2] = row[{idx, 1'b0} +: 2];
    end
    return f;
  endfunction

  function automatic logic [63:0] enc_round(input logic [63:0] d, input logic [47:0] k);
    return {d[47:0], d[63:48] ^ mg_f(d[47:0] ^ k)};
  endfunction

  function automatic logic [63:0] dec_round(input logic [63:0] d, input logic [47:0] k);
    logic [63:0] r;
    r = {d[15:0], d[63:16]};
    return {r[63:48] ^ mg_f(r[47:0] ^ k), r[47:0]};
  endfunction

  logic [STAGES-1:0] v, md, lst, adv;
  logic [USER_W-1:0] usr    [STAGES];
  logic [63:0]       dat    [STAGES];
  logic [STAGES-1:0] in_v, in_md, in_lst;
  logic [USER_W-1:0] in_usr [STAGES];
  logic [63:0]       in_dat [STAGES];
  logic [63:0]       nxt    [STAGES];

  always_comb begin
    in_v[0]   = s_axis_tvalid;
    in_md[0]  = s_axis_tdest;
    in_lst[0] = s_axis_tlast;
    in_usr[0] = s_axis_tuser;
    in_dat[0] = s_axis_tdata;
    for (int unsigned s = 1; s < STAGES; s++) begin
      in_v[s]   = v[s-1];
      in_md[s]  = md[s-1];
      in_lst[s] = lst[s-1];
      in_usr[s] = usr[s-1];
      in_dat[s] = dat[s-1];
    end
  end

  always_comb begin
    logic [63:0] blk;
    int unsigned r;
    for (int unsigned s = 0; s < STAGES; s++) begin
      blk = in_dat[s];
      for (int unsigned j = 0; j < RPS_SAFE; j++) begin
        r = s * RPS_SAFE + j;
        if (in_md[s]) blk = dec_round(blk, round_keys[(ROUNDS - 1 - r) * 48 +: 48]);
        else          blk = enc_round(blk, round_keys[r * 48 +: 48]);
      end
      nxt[s] = blk;
    end
  end

  // A stage may move unless it and every stage downstream of it is full and the sink stalls.
  always_comb begin
    logic blocked;
    blocked = !m_axis_tready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      blocked = blocked & v[STAGES-1-i];
      adv[STAGES-1-i] = !blocked;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v   <= '0;
      md  <= '0;
      lst <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        usr[s] <= '0;
        dat[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          v[s]   <= in_v[s];
          md[s]  <= in_md[s];
          lst[s] <= in_lst[s];
          usr[s] <= in_usr[s];
          dat[s] <= nxt[s];
        end
      end
    end
  end

  assign s_axis_tready = adv[0];
  assign m_axis_tvalid = v[STAGES-1];
  assign m_axis_tdata  = dat[STAGES-1];
  assign m_axis_tuser  = usr[STAGES-1];
  assign m_axis_tlast  = lst[STAGES-1];

endmodule
